// File: rtl/wb_retire_stage_pkg.sv
// wb_retire_stage_pkg
//   Shared constants for the writeback/retire stage:
//   - exception codes (ecode_e)
//   - exception flag bit positions inside ms_exc
//   - CSR_ERA, the CSR number presented on an exception commit
//   - ESUBCODE_NONE
//   - exc_to_ecode(), the priority encoder from flags to exception code
package wb_retire_stage_pkg;

  typedef enum logic [5:0] {
    ECODE_INT  = 6'h00,
    ECODE_ADEF = 6'h08,
    ECODE_ALE  = 6'h09,
    ECODE_SYS  = 6'h0B,
    ECODE_BRK  = 6'h0C,
    ECODE_INE  = 6'h0D
  } ecode_e;

  // Bit positions inside ms_exc = {ALE,BRK,SYS,INE,ADEF,INT}
  localparam int EXC_INT  = 0;
  localparam int EXC_ADEF = 1;
  localparam int EXC_INE  = 2;
  localparam int EXC_SYS  = 3;
  localparam int EXC_BRK  = 4;
  localparam int EXC_ALE  = 5;

  localparam logic [13:0] CSR_ERA       = 14'h006;
  localparam logic [8:0]  ESUBCODE_NONE = 9'h000;

  // Highest-priority flag wins: INT > ADEF > INE > SYS > BRK > ALE.
  // With no flag set the result is unused, so ALE is simply the fall-through.
  function automatic ecode_e exc_to_ecode(input logic [5:0] exc);
    ecode_e code;
    if (exc[EXC_INT])       code = ECODE_INT;
    else if (exc[EXC_ADEF]) code = ECODE_ADEF;
    else if (exc[EXC_INE])  code = ECODE_INE;
    else if (exc[EXC_SYS])  code = ECODE_SYS;
    else if (exc[EXC_BRK])  code = ECODE_BRK;
    else                    code = ECODE_ALE;
    return code;
  endfunction

endpackage

// File: rtl/wb_retire_stage_if.sv
// wb_retire_stage_if
//   MEM -> WB instruction bus.
//   Signals:
//   - ms_valid / ws_allow_in : handshake
//   - ms_* : instruction payload (PC, GPR write, CSR access, ERTN,
//            exception flags and bad VA)
//   Modports:
//   - master : MEM stage (drives payload, sees ws_allow_in)
//   - slave  : WB stage (receives payload, drives ws_allow_in)
interface wb_retire_stage_if #(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 32,
  parameter int CSR_NUM_W = 14
);
  logic                 ms_valid;
  logic                 ws_allow_in;
  logic [PC_W-1:0]      ms_pc;
  logic                 ms_gr_we;
  logic [4:0]           ms_dest;
  logic [DATA_W-1:0]    ms_result;
  logic                 ms_csr_re;
  logic                 ms_csr_we;
  logic [CSR_NUM_W-1:0] ms_csr_num;
  logic [DATA_W-1:0]    ms_csr_wmask;
  logic [DATA_W-1:0]    ms_csr_wvalue;
  logic                 ms_ertn;
  logic [5:0]           ms_exc;
  logic [DATA_W-1:0]    ms_vaddr;

  modport master (
    output ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_ertn,
           ms_exc, ms_vaddr,
    input  ws_allow_in
  );

  modport slave (
    input  ms_valid, ms_pc, ms_gr_we, ms_dest, ms_result, ms_csr_re,
           ms_csr_we, ms_csr_num, ms_csr_wmask, ms_csr_wvalue, ms_ertn,
           ms_exc, ms_vaddr,
    output ws_allow_in
  );
endinterface

// File: rtl/wb_retire_stage_fifo.sv
// wb_retire_fifo
//   Circular in-order FIFO of DEPTH entries, W bits each.
//   Ports:
//   - clk, resetn          : clock, async active-low reset
//   - push, push_data      : write at tail (caller guarantees not full)
//   - pop                  : drop head (caller guarantees not empty)
//   - clear                : discard every entry; wins over push/pop
//   - head_data            : entry at the head
//   - count                : number of valid entries
//   - tags, slot_valid     : TAG_W-bit slice of every slot, flattened, plus
//                            a per-slot valid bit, so the parent can scan
//                            queued entries without reading the whole slot
import wb_retire_stage_pkg::*;

module wb_retire_fifo #(
  parameter int DEPTH   = 2,
  parameter int W       = 8,
  parameter int TAG_LSB = 0,
  parameter int TAG_W   = 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output logic [W-1:0]           head_data,
  output logic [CNT_W-1:0]       count,
  output logic [DEPTH*TAG_W-1:0] tags,
  output logic [DEPTH-1:0]       slot_valid
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) n = '0;
    else                        n = p + PTR_W'(1);
    return n;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      if (push) begin
        wr_ptr             <= ptr_next(wr_ptr);
        slot_valid[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr             <= ptr_next(rd_ptr);
        slot_valid[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: slot_valid/count say what is meaningful.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tags
    assign tags[i*TAG_W +: TAG_W] = mem[i][TAG_LSB +: TAG_W];
  end

endmodule

// File: rtl/wb_retire_stage.sv
// wb_retire_stage
//   Writeback stage with a DEPTH-entry in-order retire queue between MEM and
//   the register file. Commits exceptions/ERTN with a whole-queue flush,
//   exports pending GPR destinations, counts retired instructions and drives
//   the debug trace (optionally de-duplicated).
//   Ports:
//   - clk, resetn                 : clock, async active-low reset
//   - ms (slave)                  : MEM -> WB instruction bus + ws_allow_in
//   - rf_ready                    : register-file write port granted
//   - rf_we/rf_waddr/rf_wdata     : GPR write
//   - csr_*                       : CSR read/write port
//   - wb_ex/ertn_flush/wb_flush   : commit pulses, upstream squash
//   - wb_pc/wb_ecode/wb_esubcode/wb_vaddr : exception information
//   - pend_mask                   : GPRs with queued writes
//   - retire_cnt                  : committed-instruction counter
//   - debug_wb_*                  : retire trace
import wb_retire_stage_pkg::*;

module wb_retire_stage #(
  parameter int DEPTH       = 2,
  parameter int PC_W        = 32,
  parameter int DATA_W      = 32,
  parameter int CSR_NUM_W   = 14,
  parameter int DEDUP_TRACE = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  wb_retire_stage_if.slave     ms,
  input  logic                 rf_ready,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [DATA_W-1:0]    rf_wdata,
  output logic [CSR_NUM_W-1:0] csr_num,
  output logic                 csr_re,
  input  logic [DATA_W-1:0]    csr_rvalue,
  output logic                 csr_we,
  output logic [DATA_W-1:0]    csr_wmask,
  output logic [DATA_W-1:0]    csr_wvalue,
  output logic                 wb_ex,
  output logic                 ertn_flush,
  output logic                 wb_flush,
  output logic [PC_W-1:0]      wb_pc,
  output logic [5:0]           wb_ecode,
  output logic [8:0]           wb_esubcode,
  output logic [DATA_W-1:0]    wb_vaddr,
  output logic [31:0]          pend_mask,
  output logic [31:0]          retire_cnt,
  output logic [PC_W-1:0]      debug_wb_pc,
  output logic [3:0]           debug_wb_rf_we,
  output logic [4:0]           debug_wb_rf_wnum,
  output logic [DATA_W-1:0]    debug_wb_rf_wdata
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Queue entry layout, LSB first. {dest, gr_we} sits contiguously so the
  // FIFO can export it as a 6-bit tag for the pending-destination scan.
  localparam int OFF_PC     = 0;
  localparam int OFF_GR     = OFF_PC + PC_W;
  localparam int OFF_DEST   = OFF_GR + 1;
  localparam int OFF_RES    = OFF_DEST + 5;
  localparam int OFF_CSRRE  = OFF_RES + DATA_W;
  localparam int OFF_CSRWE  = OFF_CSRRE + 1;
  localparam int OFF_CSRNUM = OFF_CSRWE + 1;
  localparam int OFF_WMASK  = OFF_CSRNUM + CSR_NUM_W;
  localparam int OFF_WVAL   = OFF_WMASK + DATA_W;
  localparam int OFF_ERTN   = OFF_WVAL + DATA_W;
  localparam int OFF_EXC    = OFF_ERTN + 1;
  localparam int OFF_VADDR  = OFF_EXC + 6;
  localparam int ENTRY_W    = OFF_VADDR + DATA_W;
  localparam int TAG_W      = 6;

  logic [ENTRY_W-1:0]     push_data;
  logic [ENTRY_W-1:0]     head;
  logic [CNT_W-1:0]       count;
  logic [DEPTH*TAG_W-1:0] tags;
  logic [DEPTH-1:0]       slot_valid;
  logic                   push;
  logic                   pop;

  logic                   head_valid;
  logic                   is_ex;
  logic                   is_ertn;
  logic                   is_normal;
  logic                   retire_ok;
  logic [DATA_W-1:0]      wdata_sel;
  logic                   trace_dup;
  logic [5:0]             slot_tag;

  logic [PC_W-1:0]        h_pc;
  logic                   h_gr_we;
  logic [4:0]             h_dest;
  logic [DATA_W-1:0]      h_result;
  logic                   h_csr_re;
  logic                   h_csr_we;
  logic [CSR_NUM_W-1:0]   h_csr_num;
  logic [DATA_W-1:0]      h_wmask;
  logic [DATA_W-1:0]      h_wvalue;
  logic                   h_ertn;
  logic [5:0]             h_exc;
  logic [DATA_W-1:0]      h_vaddr;

  logic [PC_W-1:0]        last_pc;
  logic [4:0]             last_dest;
  logic [DATA_W-1:0]      last_data;

  assign push_data = {ms.ms_vaddr, ms.ms_exc, ms.ms_ertn, ms.ms_csr_wvalue,
                      ms.ms_csr_wmask, ms.ms_csr_num, ms.ms_csr_we,
                      ms.ms_csr_re, ms.ms_result, ms.ms_dest, ms.ms_gr_we,
                      ms.ms_pc};

  wb_retire_fifo #(
    .DEPTH   (DEPTH),
    .W       (ENTRY_W),
    .TAG_LSB (OFF_GR),
    .TAG_W   (TAG_W)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_data  (push_data),
    .pop        (pop),
    .clear      (wb_flush),
    .head_data  (head),
    .count      (count),
    .tags       (tags),
    .slot_valid (slot_valid)
  );

  assign h_pc      = head[OFF_PC     +: PC_W];
  assign h_gr_we   = head[OFF_GR];
  assign h_dest    = head[OFF_DEST   +: 5];
  assign h_result  = head[OFF_RES    +: DATA_W];
  assign h_csr_re  = head[OFF_CSRRE];
  assign h_csr_we  = head[OFF_CSRWE];
  assign h_csr_num = head[OFF_CSRNUM +: CSR_NUM_W];
  assign h_wmask   = head[OFF_WMASK  +: DATA_W];
  assign h_wvalue  = head[OFF_WVAL   +: DATA_W];
  assign h_ertn    = head[OFF_ERTN];
  assign h_exc     = head[OFF_EXC    +: 6];
  assign h_vaddr   = head[OFF_VADDR  +: DATA_W];

  // Head classification. Exceptions and ERTN commit without waiting for
  // the register file; a normal head only waits when it really writes a GPR.
  assign head_valid = (count != '0);
  assign is_ex      = head_valid & (|h_exc);
  assign is_ertn    = head_valid & ~(|h_exc) & h_ertn;
  assign is_normal  = head_valid & ~(|h_exc) & ~h_ertn;
  assign retire_ok  = is_normal & (~h_gr_we | (h_dest == 5'd0) | rf_ready);

  assign wb_ex      = is_ex;
  assign ertn_flush = is_ertn;
  assign wb_flush   = is_ex | is_ertn;

  // Accepting during a flush would let a younger instruction survive the
  // squash; holding ws_allow_in low in reset keeps MEM from handing over
  // an instruction that would be lost.
  assign ms.ws_allow_in = resetn & (count < CNT_W'(DEPTH)) & ~wb_flush;
  assign push = ms.ms_valid & ms.ws_allow_in;
  assign pop  = retire_ok;

  assign wdata_sel = h_csr_re ? csr_rvalue : h_result;

  assign rf_we    = retire_ok & h_gr_we & (h_dest != 5'd0);
  assign rf_waddr = rf_we ? h_dest : 5'd0;
  assign rf_wdata = rf_we ? wdata_sel : '0;

  // The CSR read is issued whenever a head exists so the value is ready in
  // the retire cycle; a same-instruction write lands at the clock edge, so
  // the read returns the old value.
  assign csr_re     = head_valid;
  assign csr_num    = is_ex ? CSR_NUM_W'(CSR_ERA) : (head_valid ? h_csr_num : '0);
  assign csr_we     = retire_ok & h_csr_we;
  assign csr_wmask  = head_valid ? h_wmask : '0;
  assign csr_wvalue = head_valid ? h_wvalue : '0;

  assign wb_pc       = head_valid ? h_pc : '0;
  assign wb_vaddr    = head_valid ? h_vaddr : '0;
  assign wb_ecode    = is_ex ? exc_to_ecode(h_exc) : 6'h00;
  assign wb_esubcode = ESUBCODE_NONE;

  // Scan every valid slot; dest 0 is never marked since r0 is never written.
  always_comb begin
    pend_mask = '0;
    slot_tag  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_tag = tags[i*TAG_W +: TAG_W];
      if (slot_valid[i] && slot_tag[0] && (slot_tag[5:1] != 5'd0)) begin
        pend_mask[slot_tag[5:1]] = 1'b1;
      end
    end
  end

  // Trace: suppressed when the same {pc, dest, data} was the last one sent.
  // The shadow triple can never match spuriously after reset because a
  // traced write always has a non-zero dest.
  assign trace_dup = (h_pc == last_pc) && (h_dest == last_dest) &&
                     (wdata_sel == last_data);
  assign debug_wb_pc       = rf_we ? h_pc : '0;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
  assign debug_wb_rf_we    = (rf_we && !((DEDUP_TRACE != 0) && trace_dup)) ?
                             4'hF : 4'h0;

  // Retire counter (normal retires and ERTN; exceptions do not count) and
  // the trace shadow triple, refreshed on every GPR write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retire_cnt <= '0;
      last_pc    <= '0;
      last_dest  <= '0;
      last_data  <= '0;
    end else begin
      if (retire_ok || is_ertn) retire_cnt <= retire_cnt + 32'd1;
      if (rf_we) begin
        last_pc   <= h_pc;
        last_dest <= h_dest;
        last_data <= wdata_sel;
      end
    end
  end

endmodule
